// File: rtl/irq_dispatch.sv
// irq_dispatch: vectored interrupt dispatcher.
// Picks one winner from up to NUM_SRC level-pending sources, drives an
// active-low registered interrupt, and runs the claim / EOI handshake over
// the shared 5-bit CSR bus.
//
// CSR map (relative to BASE_ADDR):
//   +0 MASK   RW  1 = source masked, zero-extended on read
//   +1 STATUS RO  {in_service, irq_asserted, 3'b0, vec}
//   +2 CLAIM  RO  {1'b1, 4'b0, vec} in ASSERT (read strobe claims), else 0
//   +3 EOI    WO  ends service, reads 0
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   csr_a         CSR address
//   csr_di        CSR write data
//   csr_we        write strobe
//   csr_re        read strobe (side effect only at CLAIM)
//   csr_do        combinational read data
//   pend          level pending inputs, synchronous to clk
//   irq_n         SoC interrupt, active low, registered
//
// Build option: define IRQ_DISPATCH_RR_EN for round-robin selection with a
// last-serviced pointer; otherwise fixed priority (lowest index wins).
module irq_dispatch #(
  parameter logic [4:0]  BASE_ADDR = 5'h0,
  parameter int unsigned NUM_SRC   = 8,
  parameter int unsigned IRQ_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         csr_a,
  input  logic [7:0]         csr_di,
  input  logic               csr_we,
  input  logic               csr_re,
  output logic [7:0]         csr_do,
  input  logic [NUM_SRC-1:0] pend,
  output logic               irq_n
);

  localparam logic [4:0] A_MASK   = BASE_ADDR;
  localparam logic [4:0] A_STATUS = BASE_ADDR + 5'd1;
  localparam logic [4:0] A_CLAIM  = BASE_ADDR + 5'd2;
  localparam logic [4:0] A_EOI    = BASE_ADDR + 5'd3;

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE, S_GAP} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic [2:0]         vec;
  logic [3:0]         gap_cnt;
`ifdef IRQ_DISPATCH_RR_EN
  localparam logic [2:0] LAST_RST = 3'(NUM_SRC - 1);
  logic [2:0]         last;
`endif

  logic [7:0] mask8;
  logic [7:0] elig8;
  logic [7:0] elig_chk8;
  logic       mask_wr;
  logic       claim;
  logic       eoi;
  logic       withdrawn;
  logic       found;
  logic [2:0] win;
  logic [2:0] cand;

  assign mask_wr = csr_we && (csr_a == A_MASK);
  assign claim   = csr_re && (csr_a == A_CLAIM) && (state == S_ASSERT);
  assign eoi     = csr_we && (csr_a == A_EOI) && (state == S_SERVICE);

  // The withdrawal check sees a MASK value being written this cycle, so
  // masking the active vector releases irq_n on the very next edge.
  always_comb begin
    mask8                  = '0;
    mask8[NUM_SRC-1:0]     = mask;
    elig8                  = '0;
    elig8[NUM_SRC-1:0]     = pend & ~mask;
    elig_chk8              = '0;
    elig_chk8[NUM_SRC-1:0] = pend & ~(mask_wr ? csr_di[NUM_SRC-1:0] : mask);
    withdrawn              = !elig_chk8[vec];
  end

  // Winner search; the first eligible candidate in search order wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
`ifdef IRQ_DISPATCH_RR_EN
      cand = 3'((32'(last) + 32'd1 + i) % NUM_SRC);
`else
      cand = 3'(i);
`endif
      if (!found && elig8[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      irq_n   <= 1'b1;
      mask    <= '1;
      vec     <= '0;
      gap_cnt <= '0;
`ifdef IRQ_DISPATCH_RR_EN
      last    <= LAST_RST;
`endif
    end else begin
      if (mask_wr) mask <= csr_di[NUM_SRC-1:0];
      case (state)
        S_IDLE: begin
          if (found) begin
            vec   <= win;
            irq_n <= 1'b0;
            state <= S_ASSERT;
          end
        end
        S_ASSERT: begin
          // A claim in the same cycle as a withdrawal takes precedence.
          if (claim) begin
            irq_n <= 1'b1;
            state <= S_SERVICE;
          end else if (withdrawn) begin
            irq_n <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            gap_cnt <= 4'(IRQ_GAP);
`ifdef IRQ_DISPATCH_RR_EN
            last    <= vec;
`endif
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          // Leaving on the decrement to zero gives IRQ_GAP cycles in GAP.
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_do = '0;
    case (csr_a)
      A_MASK:   csr_do = mask8;
      A_STATUS: csr_do = {(state == S_SERVICE), !irq_n, 3'b000, vec};
      A_CLAIM:  if (state == S_ASSERT) csr_do = {1'b1, 4'b0000, vec};
      default:  csr_do = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_dispatch.sv
// Testbench for irq_dispatch: directed stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares them.
module tb_irq_dispatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] csr_a = '0;
  logic [7:0] csr_di = '0;
  logic       csr_we = 1'b0;
  logic       csr_re = 1'b0;
  logic [7:0] csr_do;
  logic [7:0] pend = '0;
  logic       irq_n;

  localparam logic [4:0] A_MASK   = 5'h0;
  localparam logic [4:0] A_STATUS = 5'h1;
  localparam logic [4:0] A_CLAIM  = 5'h2;
  localparam logic [4:0] A_EOI    = 5'h3;

  irq_dispatch #(.BASE_ADDR(5'h0), .NUM_SRC(8), .IRQ_GAP(4)) dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_re(csr_re), .csr_do(csr_do), .pend(pend), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 = csr_do, 1 = irq_n
    logic [7:0] exp;
    string      name;
  } chk_t;

  chk_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    chk_t       e;
    logic [7:0] act;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = (e.kind == 1) ? {7'b0, irq_n} : csr_do;
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_irq(input logic v, input string name);
    q.push_back('{1, {7'b0, v}, name});
  endtask

  task automatic csr_wr(input logic [4:0] a, input logic [7:0] d);
    csr_a  = a;
    csr_di = d;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic csr_rd(input logic [4:0] a, input logic [7:0] e, input string name);
    csr_a  = a;
    csr_re = 1'b1;
    q.push_back('{0, e, name});
    tick();
    csr_re = 1'b0;
  endtask

  logic [2:0] rr_seq [4];
  logic [2:0] v5;

  initial begin
`ifdef IRQ_DISPATCH_RR_EN
    rr_seq = '{3'd0, 3'd3, 3'd0, 3'd3};
    v5     = 3'd4;
`else
    rr_seq = '{3'd0, 3'd0, 3'd0, 3'd0};
    v5     = 3'd2;
`endif
    tick();
    tick();
    rst = 1'b0;

    // reset state
    exp_irq(1'b1, "rst_irq");
    csr_rd(A_MASK, 8'hFF, "rst_mask");
    csr_rd(A_STATUS, 8'h00, "rst_status");
    csr_rd(A_CLAIM, 8'h00, "rst_claim");
    csr_rd(A_EOI, 8'h00, "rst_eoi_rd");
    csr_rd(5'h10, 8'h00, "unmapped");

    // single source 5
    csr_wr(A_MASK, 8'h00);
    csr_rd(A_MASK, 8'h00, "mask_rd");
    pend = 8'h20;
    exp_irq(1'b1, "pre_assert");
    tick();
    exp_irq(1'b0, "assert5");
    csr_rd(A_STATUS, 8'h45, "status_assert");
    csr_rd(A_CLAIM, 8'h85, "claim5");
    exp_irq(1'b1, "post_claim");
    csr_rd(A_STATUS, 8'h85, "status_service");

    // EOI gap: high for 5 cycles after the EOI cycle
    csr_wr(A_EOI, 8'h5A);
    for (int i = 0; i < 5; i++) begin
      exp_irq(1'b1, $sformatf("gap_hi%0d", i));
      tick();
    end
    exp_irq(1'b0, "gap_reassert");
    csr_rd(A_CLAIM, 8'h85, "claim5b");
    pend = 8'h00;
    csr_wr(A_EOI, 8'h00);
    repeat (6) tick();
    exp_irq(1'b1, "idle_after");

    // selection order with two pending sources
    pend = 8'h09;
    tick();
    for (int r = 0; r < 4; r++) begin
      exp_irq(1'b0, $sformatf("rr_irq%0d", r));
      csr_rd(A_CLAIM, {5'b10000, rr_seq[r]}, $sformatf("rr_claim%0d", r));
      exp_irq(1'b1, $sformatf("rr_svc%0d", r));
      csr_wr(A_EOI, 8'h00);
      repeat (5) tick();
    end
    pend = 8'h00;
    tick();
    exp_irq(1'b1, "withdraw_pend");
    csr_rd(A_STATUS, 8'h00, "status_withdraw");

    // withdrawal by MASK write on vector 2, then re-selection
    pend = 8'h04;
    tick();
    exp_irq(1'b0, "assert2");
    csr_rd(A_STATUS, 8'h42, "status_v2");
    pend = 8'h14;
    csr_wr(A_MASK, 8'h04);
    exp_irq(1'b1, "mask_withdraw");
    tick();
    exp_irq(1'b0, "reselect4");
    csr_rd(A_STATUS, 8'h44, "status_v4");
    csr_wr(A_MASK, 8'h14);
    exp_irq(1'b1, "mask_withdraw2");
    tick();
    exp_irq(1'b1, "stay_idle");
    csr_rd(A_STATUS, 8'h04, "status_idle");

    // claim and pend drop in the same cycle: claim wins
    csr_wr(A_MASK, 8'h00);
    tick();
    exp_irq(1'b0, "assert_race");
    pend = 8'h00;
    csr_rd(A_CLAIM, {5'b10000, v5}, "claim_race");
    exp_irq(1'b1, "race_svc_irq");
    csr_rd(A_STATUS, {5'b10000, v5}, "race_status");
    csr_rd(A_CLAIM, 8'h00, "claim_in_service");

    // reset during service
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_irq(1'b1, "rst_svc_irq");
    csr_rd(A_MASK, 8'hFF, "rst_svc_mask");
    csr_rd(A_STATUS, 8'h00, "rst_svc_status");
    csr_wr(A_EOI, 8'h00);
    csr_rd(A_STATUS, 8'h00, "eoi_ignored");
    exp_irq(1'b1, "eoi_ignored_irq");

    tick();
    tick();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
